// File: rtl/shot_timer.sv
// Shot timer: timestamps each channel's first slope-detect edge relative to the
// earliest arrival, closes on all-hit or timeout, and holds results for readout.

module shot_timer_lane #(
  parameter int CW = 16
) (
  input  logic          clk8M,
  input  logic          reset,
  input  logic          clr,
  input  logic          ld_en,
  input  logic          trig,
  input  logic          run,
  input  logic [CW-1:0] cnt,
  input  logic          det,
  output logic          en_q,
  output logic          rise,
  output logic          hit,
  output logic          first,
  output logic [CW-1:0] ts
);
  logic det_q;

  // A det already high when armed needs a fresh low->high to count.
  assign rise = det & ~det_q & en_q;

  always_ff @(posedge clk8M) begin
    if (reset) begin
      det_q <= 1'b0;
      en_q  <= 1'b0;
      hit   <= 1'b0;
      first <= 1'b0;
      ts    <= '0;
    end else begin
      det_q <= det;
      if (clr) begin
        en_q  <= ld_en;
        hit   <= 1'b0;
        first <= 1'b0;
        ts    <= '0;
      end else if (trig && rise) begin
        hit   <= 1'b1;
        first <= 1'b1;
        ts    <= '0;
      end else if (run && rise && !hit) begin
        hit <= 1'b1;
        ts  <= cnt;
      end
    end
  end
endmodule

module shot_timer #(
  parameter int            NCH     = 4,
  parameter int            CW      = 16,
  parameter logic [CW-1:0] TIMEOUT = 16'd8000,
  localparam int           SW      = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk8M,
  input  logic           reset,
  input  logic           arm,
  input  logic           abort,
  input  logic [NCH-1:0] ch_en,
  input  logic [NCH-1:0] det,
  input  logic [SW-1:0]  ts_sel,
  output logic           armed,
  output logic           busy,
  output logic           done,
  output logic           timeout,
  output logic [NCH-1:0] hit,
  output logic [NCH-1:0] first,
  output logic [CW-1:0]  ts_data
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARMED = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]              state;
  logic [CW-1:0]           cnt;
  logic [NCH-1:0]          en_q, rise;
  logic [NCH-1:0][CW-1:0]  ts;
  logic                    clr, trig, run, all_hit;

  assign clr     = arm && !abort && (state == S_IDLE || state == S_DONE);
  assign trig    = (state == S_ARMED) && !abort;
  assign run     = (state == S_RUN) && !abort;
  assign all_hit = ((hit | rise) & en_q) == en_q;

  for (genvar i = 0; i < NCH; i++) begin : g_lane
    shot_timer_lane #(.CW(CW)) u_lane (
      .clk8M (clk8M),
      .reset (reset),
      .clr   (clr),
      .ld_en (ch_en[i]),
      .trig  (trig),
      .run   (run),
      .cnt   (cnt),
      .det   (det[i]),
      .en_q  (en_q[i]),
      .rise  (rise[i]),
      .hit   (hit[i]),
      .first (first[i]),
      .ts    (ts[i])
    );
  end

  always_ff @(posedge clk8M) begin
    if (reset) begin
      state   <= S_IDLE;
      cnt     <= '0;
      timeout <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: if (clr) begin
          state   <= S_ARMED;
          cnt     <= '0;
          timeout <= 1'b0;
        end
        S_ARMED: if (abort) state <= S_IDLE;
          else if (|rise) begin
            state <= S_RUN;
            cnt   <= CW'(1);
          end
        S_RUN: if (abort) state <= S_IDLE;
          else begin
            if (cnt != '1) cnt <= cnt + 1'b1;
            // all-hit wins over timeout when the last channel lands on the timeout cycle
            if (all_hit) state <= S_DONE;
            else if (cnt == TIMEOUT) begin
              state   <= S_DONE;
              timeout <= 1'b1;
            end
          end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign armed = (state == S_ARMED);
  assign busy  = (state == S_RUN);
  assign done  = (state == S_DONE);

  // Select codes with no channel behind them read back as zero.
  logic [CW-1:0] ts_tab [2**SW];
  for (genvar i = 0; i < 2**SW; i++) begin : g_tab
    if (i < NCH) begin : g_ch
      assign ts_tab[i] = ts[i];
    end else begin : g_nc
      assign ts_tab[i] = '0;
    end
  end
  assign ts_data = ts_tab[ts_sel];
endmodule

// File: tb/tb_shot_timer.sv
// Randomized + directed bench for shot_timer; expectations come from an
// event-level model (first-edge times per channel, trigger, close cycle).

module tb_shot_timer;
  localparam int NCH  = 4;
  localparam int CW   = 16;
  localparam int TMO  = 8000;
  localparam int MAXW = 8400;
  localparam int BIG  = 1 << 30;

  logic           clk8M = 1'b0;
  logic           reset, arm, abort;
  logic [NCH-1:0] ch_en, det;
  logic [1:0]     ts_sel;
  logic           armed, busy, done, timeout;
  logic [NCH-1:0] hit, first;
  logic [CW-1:0]  ts_data;

  int n_vec = 0;
  int n_err = 0;
  logic [NCH-1:0] wave [MAXW];

  shot_timer #(.NCH(NCH), .CW(CW), .TIMEOUT(16'(TMO))) dut (
    .clk8M(clk8M), .reset(reset), .arm(arm), .abort(abort), .ch_en(ch_en),
    .det(det), .ts_sel(ts_sel), .armed(armed), .busy(busy), .done(done),
    .timeout(timeout), .hit(hit), .first(first), .ts_data(ts_data)
  );

  always #5 clk8M = ~clk8M;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr_wave();
    for (int i = 0; i < MAXW; i++) wave[i] = '0;
  endtask

  task automatic pulse(input int c, input int s, input int len);
    for (int t = s; t < s + len; t++) if (t < MAXW) wave[t][c] = 1'b1;
  endtask

  // wave[k] is the det value sampled at the k-th posedge; arm sampled at k=0.
  task automatic run_shot(input logic [NCH-1:0] en, input int abort_i, input bit arm_abort,
                          input int reset_i);
    int ki [NCH];
    int t0, close, lim, end_k, abort_at, reset_at, maxk, kk;
    bit tmo;
    logic [NCH-1:0] eh, ef;
    logic [3:0] es;
    int ets;
    abort_at = abort_i;
    reset_at = reset_i;
    t0 = BIG;
    for (int c = 0; c < NCH; c++) begin
      ki[c] = BIG;
      if (en[c])
        for (int k = 1; k < MAXW; k++)
          if (wave[k][c] && !wave[k-1][c]) begin ki[c] = k; break; end
      if (ki[c] < t0) t0 = ki[c];
    end
    close = BIG;
    tmo   = 1'b0;
    if (t0 < BIG) begin
      maxk = 0;
      for (int c = 0; c < NCH; c++) if (en[c] && ki[c] > maxk) maxk = ki[c];
      if (maxk - t0 <= TMO) close = t0 + ((maxk - t0 > 1) ? maxk - t0 : 1);
      else begin close = t0 + TMO; tmo = 1'b1; end
    end
    if (abort_at >= close) abort_at = -1;
    if (reset_at >= close) reset_at = -1;
    if (abort_at < 0 && reset_at < 0 && close == BIG) abort_at = 40;
    lim   = (abort_at >= 0) ? abort_at - 1 : close;
    end_k = (abort_at >= 0) ? abort_at + 6 : (reset_at >= 0) ? reset_at + 6 : close + 3;
    if (end_k >= MAXW) end_k = MAXW - 1;

    repeat (2) begin
      @(negedge clk8M);
      det = wave[0]; arm = 1'b0; abort = 1'b0; reset = 1'b0;
    end
    for (int k = 0; k <= end_k + 1; k++) begin
      @(negedge clk8M);
      if (k > 0) begin
        kk = k - 1;
        if (reset_at >= 0 && kk >= reset_at) begin
          es = '0; eh = '0;
        end else if (abort_at >= 0 && kk >= abort_at) begin
          es = '0;
          for (int c = 0; c < NCH; c++) eh[c] = (ki[c] < abort_at);
        end else begin
          es = {kk < t0, kk >= t0 && kk < close, kk >= close, kk >= close && tmo};
          for (int c = 0; c < NCH; c++) eh[c] = (ki[c] <= kk) && (ki[c] <= close);
        end
        chk($sformatf("ctl k=%0d", kk), {armed, busy, done, timeout, hit}, {es, eh});
      end
      if (k <= end_k) begin
        det   = wave[k];
        arm   = (k == 0) || (arm_abort && k == abort_at);
        abort = (k == abort_at);
        reset = (k == reset_at);
        ch_en = (k == 0) ? en : NCH'($urandom);
      end else begin
        arm = 1'b0; abort = 1'b0; reset = 1'b0;
      end
    end
    ef = '0;
    for (int c = 0; c < NCH; c++) begin
      ets = 0;
      if (reset_at < 0 && ki[c] <= lim) begin
        ets   = ki[c] - t0;
        ef[c] = (ki[c] == t0);
      end
      ts_sel = 2'(c);
      #1;
      chk($sformatf("ts ch%0d", c), 32'(ts_data), ets);
    end
    chk("first", 32'(first), 32'(ef));
  endtask

  initial begin
    logic [NCH-1:0] en;
    int ab;
    bit aa;
    reset = 1'b1; arm = 1'b0; abort = 1'b0; ch_en = '0; det = '0; ts_sel = '0;
    repeat (3) @(negedge clk8M);
    chk("reset ctl", {armed, busy, done, timeout, hit, first}, 32'h0);
    chk("reset ts", 32'(ts_data), 32'h0);
    reset = 1'b0;

    // normal shot
    clr_wave(); pulse(2, 10, 3); pulse(0, 15, 2); pulse(3, 22, 4); pulse(1, 50, 2);
    run_shot(4'hF, -1, 1'b0, -1);
    // simultaneous first arrival
    clr_wave(); pulse(0, 6, 2); pulse(1, 6, 3); pulse(2, 9, 2); pulse(3, 13, 1);
    run_shot(4'hF, -1, 1'b0, -1);
    // timeout with two channels missing
    clr_wave(); pulse(0, 4, 2); pulse(3, 104, 2);
    run_shot(4'hF, -1, 1'b0, -1);
    // last channel exactly on the timeout cycle: no timeout
    clr_wave(); pulse(0, 5, 2); pulse(1, 5 + TMO, 2);
    run_shot(4'b0011, -1, 1'b0, -1);
    // last channel one cycle too late: timeout, not captured
    clr_wave(); pulse(0, 5, 2); pulse(1, 6 + TMO, 2);
    run_shot(4'b0011, -1, 1'b0, -1);
    // masking and pre-high at arm
    clr_wave(); pulse(0, 0, 6); pulse(3, 3, 2); pulse(1, 10, 2); pulse(0, 12, 2); pulse(2, 19, 2);
    run_shot(4'b0111, -1, 1'b0, -1);
    // abort mid-run after two hits, then re-arm
    clr_wave(); pulse(0, 5, 2); pulse(1, 9, 2); pulse(2, 30, 2); pulse(3, 35, 2);
    run_shot(4'hF, 20, 1'b0, -1);
    clr_wave(); pulse(3, 7, 2); pulse(1, 8, 2); pulse(0, 20, 2); pulse(2, 21, 2);
    run_shot(4'hF, -1, 1'b0, -1);
    // arm+abort together while armed
    clr_wave(); pulse(0, 50, 2); pulse(1, 50, 2);
    run_shot(4'hF, 10, 1'b1, -1);
    // reset mid-run with hit=0011; later edges ignored
    clr_wave(); pulse(0, 5, 2); pulse(1, 7, 2); pulse(2, 18, 2); pulse(3, 40, 2);
    run_shot(4'hF, -1, 1'b0, 15);
    // no channels enabled
    clr_wave(); pulse(0, 5, 2); pulse(2, 9, 2);
    run_shot(4'h0, 30, 1'b0, -1);

    for (int n = 0; n < 40; n++) begin
      clr_wave();
      en = NCH'($urandom_range(0, 15));
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 3) == 0) pulse(c, 0, $urandom_range(1, 3));
        repeat ($urandom_range(1, 3)) pulse(c, $urandom_range(5, 150), $urandom_range(1, 4));
      end
      ab = ($urandom_range(0, 3) == 0 || en == '0) ? int'($urandom_range(1, 80)) : -1;
      aa = 1'($urandom_range(0, 1));
      run_shot(en, ab, aa, -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/shot_timer.md
Name: shot_timer

Overview:
- Consumes the per-sensor `det` pulses produced by the slope detectors (one detector per channel, 8 MHz domain).
- Timestamps the first rising edge of each channel relative to the earliest arrival in a shot.
- Stops on all-hit or timeout, then holds the timestamps for readout by the host/soft CPU.
- Sits between the slope-detector array and the register interface.

Parameters:
- NCH, 4, number of sensor channels.
- CW, 16, timestamp/counter width in bits.
- TIMEOUT, 16'd8000, cycles after first arrival before the shot is forced closed (1 ms at 8 MHz).

Ports:
- clk8M  input  1  8 MHz clock, shared with slope-detector filter stage.
- reset  input  1  synchronous, active-high reset.
- arm  input  1  one-cycle pulse; starts a new shot capture.
- abort  input  1  one-cycle pulse; returns to IDLE, keeps captured data.
- ch_en  input  NCH  channel enable mask, sampled on arm.
- det  input  NCH  slope-detect outputs, one bit per channel.
- ts_sel  input  clog2(NCH)  channel select for timestamp readout.
- armed  output  1  high in ARMED state.
- busy  output  1  high in RUN state.
- done  output  1  high in DONE state.
- timeout  output  1  shot closed by TIMEOUT; valid while done.
- hit  output  NCH  per-channel captured flag.
- first  output  NCH  channels whose edge occurred on the trigger cycle.
- ts_data  output  CW  timestamp of channel ts_sel (0 if not hit).

Behaviour:
- Reset: state=IDLE; armed=busy=done=timeout=0; hit=first=0; all timestamps=0; counter=0; det_q=0; en_q=0.
- Edge detect: det_q<=det every cycle in all states; rise = det & ~det_q & en_q. A det already high at arm does not fire until it falls and rises again.
- States:
  - IDLE: arm -> ARMED. On that transition: en_q<=ch_en; hit, first, timestamps, timeout cleared.
  - ARMED: on the first cycle any rise bit is set -> RUN.
    - counter<=1.
    - Each rising channel: hit=1, first=1, ts=0.
    - Simultaneous rises on several channels all get ts=0 and first=1.
  - RUN: counter increments by 1 each cycle. Any rise on a channel with hit=0 sets hit=1 and ts=counter (current value, before increment). Already-hit channels ignore further edges.
  - RUN -> DONE when (hit | new rises) covers en_q, in the same cycle as the last capture. done asserts the next cycle.
  - RUN -> DONE with timeout=1 when counter==TIMEOUT and not all enabled channels are hit. A rise on that same cycle is still captured, and all-hit takes priority: timeout=0 if the final channel arrives on that cycle.
  - DONE: outputs held. arm -> ARMED (with the clears above). Otherwise stays.
- abort in ARMED or RUN -> IDLE next cycle. hit/ts keep partial values; done stays 0.
- Priority: abort over arm. arm is ignored in ARMED and RUN. reset overrides everything.
- ch_en==0 at arm: enters ARMED; no rise possible; remains there until abort.
- Counter saturates at 2^CW-1 (only reachable if TIMEOUT ≥ 2^CW-1); it never wraps.
- Readout: ts_data is combinational mux of ts[ts_sel]. ts_sel≥NCH returns 0.
- Latency: det registered edge -> hit/ts visible 1 cycle after the rising det sample.
- No combinational path from det to any output.

Test Plan:
- Normal shot: arm, ch_en=4'hF; det rises ch2 at T, ch0 T+5, ch3 T+12, ch1 T+40 -> ts={ch0:5, ch1:40, ch2:0, ch3:12}, first=4'b0100, done=1 and timeout=0 one cycle after the ch1 capture.
- Simultaneous first arrival: ch0 and ch1 rise on the same cycle, ch2 +3, ch3 +7 -> ts0=ts1=0, first=4'b0011, ts2=3, ts3=7.
- Timeout: ch_en=4'hF, only ch0 and ch3 rise (ch3 at +100) -> after 8000 cycles done=1, timeout=1, hit=4'b1001, ts1=ts2=0.
- Masking/pre-high: ch_en=4'b0111 with det[0] high at arm; det[3] pulses; det[0] falls, then ch1 rises, ch0 re-rises +2, ch2 +9 -> trigger on ch1, ts0=2, ts2=9, hit[3]=0, done without timeout.
- Abort and re-arm: abort mid-RUN after two hits -> IDLE, hit retained, done=0. arm -> hit cleared, new shot captures correctly. Simultaneous arm+abort in ARMED -> IDLE.
- Reset mid-RUN: assert reset with hit=4'b0011 -> next cycle all outputs 0, state IDLE, det edges ignored until arm.
